// File: rtl/call_stack_lifo_pkg.sv
// call_stack_lifo_pkg: shared frame constants and occupancy state encodings for the fib frame stack
package call_stack_lifo_pkg;
    localparam int DEF_WORD_W  = 8;
    localparam int FRAME_BYTES = 8;
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } occ_t;
endpackage

// File: rtl/call_stack_lifo_regfile.sv
// lifo_regfile: unreset frame storage with one write port and one asynchronous read port
module lifo_regfile #(
    parameter int W     = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/call_stack_lifo.sv
// call_stack_lifo: LIFO of {ra, a0} frames with byte stack pointer, occupancy flags and sticky errors
module call_stack_lifo
    import call_stack_lifo_pkg::*;
#(
    parameter int         WORD_W  = DEF_WORD_W,
    parameter int         DEPTH   = 16,
    parameter logic [7:0] SP_BASE = 8'hFF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [WORD_W-1:0]        push_a0,
    input  logic [WORD_W-1:0]        push_ra,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [WORD_W-1:0]        pop_a0,
    output logic [WORD_W-1:0]        pop_ra,
    output logic                     top_a0_zero,
    output logic [7:0]               sp,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     err_ovf,
    output logic                     err_udf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    occ_t            state;
    logic            push_fire, pop_fire;
    logic [CW-1:0]   cnt_next;
    logic [AW-1:0]   top_idx, wr_idx;
    logic [2*WORD_W-1:0] rd;
    assign full       = state == ST_FULL;
    assign empty      = state == ST_EMPTY;
    assign push_ready = !full;
    assign pop_valid  = !empty;
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = pop_ready && pop_valid;
    assign top_idx    = AW'(count - CW'(1));
    // Simultaneous push and pop replaces the top frame in place
    assign wr_idx     = pop_fire ? top_idx : AW'(count);
    assign cnt_next   = (push_fire && !pop_fire) ? count + CW'(1) :
                        (pop_fire && !push_fire) ? count - CW'(1) : count;
    assign pop_a0      = empty ? '0 : rd[WORD_W-1:0];
    assign pop_ra      = empty ? '0 : rd[2*WORD_W-1:WORD_W];
    assign top_a0_zero = pop_valid && pop_a0 == '0;
    lifo_regfile #(.W(2*WORD_W), .DEPTH(DEPTH)) u_rf (
        .clk   (clk),
        .we    (push_fire && rst_n && !clear),
        .waddr (wr_idx),
        .wdata ({push_ra, push_a0}),
        .raddr (top_idx),
        .rdata (rd)
    );
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count   <= '0;
            sp      <= SP_BASE;
            state   <= ST_EMPTY;
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            count   <= cnt_next;
            sp      <= 8'(int'(SP_BASE) - FRAME_BYTES * int'(cnt_next));
            state   <= cnt_next == '0 ? ST_EMPTY :
                       cnt_next == CW'(DEPTH) ? ST_FULL : ST_PARTIAL;
            err_ovf <= err_ovf | (push_valid && !push_ready);
            err_udf <= err_udf | (pop_ready && !pop_valid);
        end
    end
endmodule

// File: tb/tb_call_stack_lifo.sv
// tb_call_stack_lifo: directed table-driven and hand-sequenced checks of the frame stack
module tb_call_stack_lifo;
    logic       clk = 1'b0;
    logic       rst_n, clear, push_valid, pop_ready;
    logic [7:0] push_a0, push_ra;
    logic       push_ready, pop_valid, top_a0_zero, full, empty, err_ovf, err_udf;
    logic [7:0] pop_a0, pop_ra, sp;
    logic [4:0] count;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    call_stack_lifo dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_a0(push_a0), .push_ra(push_ra),
        .pop_valid(pop_valid), .pop_ready(pop_ready),
        .pop_a0(pop_a0), .pop_ra(pop_ra), .top_a0_zero(top_a0_zero),
        .sp(sp), .count(count), .full(full), .empty(empty),
        .err_ovf(err_ovf), .err_udf(err_udf)
    );

    typedef struct {
        logic       pv, pr, clr;
        logic [7:0] a0, ra;
        logic [4:0] cnt;
        logic [7:0] sp, ea0, era;
        logic       tz, emp, ovf, udf;
    } vec_t;

    function automatic vec_t v(bit pv, bit pr, bit clr, int a0, int ra, int cnt, int spv,
                               int ea0, int era, bit tz, bit emp, bit ovf, bit udf);
        vec_t r;
        r.pv = pv; r.pr = pr; r.clr = clr;
        r.a0 = 8'(a0); r.ra = 8'(ra); r.cnt = 5'(cnt); r.sp = 8'(spv);
        r.ea0 = 8'(ea0); r.era = 8'(era);
        r.tz = tz; r.emp = emp; r.ovf = ovf; r.udf = udf;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(bit pv, bit pr, bit clr, logic [7:0] a0, logic [7:0] ra);
        push_valid = pv; pop_ready = pr; clear = clr; push_a0 = a0; push_ra = ra;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[12];

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 8'h00, 8'h00);
        // pushes/pops of (5,1),(4,2),(3,3); underflow; zero-a0 frame; push+pop overwrite; clear
        vecs[0]  = v(1,0,0, 5,1,  1,'hF7, 5,1, 0,0,0,0);
        vecs[1]  = v(1,0,0, 4,2,  2,'hEF, 4,2, 0,0,0,0);
        vecs[2]  = v(1,0,0, 3,3,  3,'hE7, 3,3, 0,0,0,0);
        vecs[3]  = v(0,1,0, 0,0,  2,'hEF, 4,2, 0,0,0,0);
        vecs[4]  = v(0,1,0, 0,0,  1,'hF7, 5,1, 0,0,0,0);
        vecs[5]  = v(0,1,0, 0,0,  0,'hFF, 0,0, 0,1,0,0);
        vecs[6]  = v(0,1,0, 0,0,  0,'hFF, 0,0, 0,1,0,1);
        vecs[7]  = v(1,0,0, 0,9,  1,'hF7, 0,9, 1,0,0,1);
        vecs[8]  = v(1,0,0, 6,8,  2,'hEF, 6,8, 0,0,0,1);
        vecs[9]  = v(1,1,0, 7,7,  2,'hEF, 7,7, 0,0,0,1);
        vecs[10] = v(0,1,0, 0,0,  1,'hF7, 0,9, 1,0,0,1);
        vecs[11] = v(0,0,1, 0,0,  0,'hFF, 0,0, 0,1,0,0);

        step(); step();
        rst_n = 1'b1;
        step(); step(); step();
        chk("rst_sp", sp, 8'hFF);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_pop_a0", pop_a0, 0);
        chk("rst_err", {err_ovf, err_udf}, 0);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].pv, vecs[i].pr, vecs[i].clr, vecs[i].a0, vecs[i].ra);
            step();
            chk($sformatf("v%0d_count", i), count, vecs[i].cnt);
            chk($sformatf("v%0d_sp", i), sp, vecs[i].sp);
            chk($sformatf("v%0d_pop", i), {pop_a0, pop_ra}, {vecs[i].ea0, vecs[i].era});
            chk($sformatf("v%0d_flags", i), {top_a0_zero, empty, pop_valid},
                {vecs[i].tz, vecs[i].emp, !vecs[i].emp});
            chk($sformatf("v%0d_err", i), {err_ovf, err_udf}, {vecs[i].ovf, vecs[i].udf});
        end

        // fill to capacity, then overflow attempt
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 0, 8'(i + 1), 8'(8'h10 + i));
            step();
        end
        drive(0, 0, 0, 8'h00, 8'h00);
        chk("fill_count", count, 16);
        chk("fill_sp", sp, 8'h7F);
        chk("fill_full", {full, push_ready}, 2'b10);
        drive(1, 0, 0, 8'h99, 8'h99);
        step();
        drive(0, 0, 0, 8'h00, 8'h00);
        chk("ovf_err", err_ovf, 1);
        chk("ovf_count", count, 16);
        chk("ovf_top", {pop_a0, pop_ra}, {8'd16, 8'h1F});
        drive(0, 1, 0, 8'h00, 8'h00);
        step();
        drive(0, 0, 0, 8'h00, 8'h00);
        chk("unfull_full", {full, push_ready}, 2'b01);
        chk("unfull_sp", sp, 8'h87);
        chk("unfull_top", {pop_a0, pop_ra}, {8'd15, 8'h1E});
        chk("ovf_sticky", err_ovf, 1);

        drive(0, 0, 1, 8'h00, 8'h00);
        step();
        drive(0, 0, 0, 8'h00, 8'h00);
        chk("clr_err", err_ovf, 0);
        chk("clr_count", count, 0);

        // reset in the middle of an unwind
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 8'(8'h40 + i), 8'h01);
            step();
        end
        chk("pre_rst_count", count, 4);
        drive(0, 1, 0, 8'h00, 8'h00);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drive(0, 0, 0, 8'h00, 8'h00);
        chk("midrst_count", count, 0);
        chk("midrst_sp", sp, 8'hFF);
        chk("midrst_pop", {empty, pop_a0}, {1'b1, 8'h00});
        drive(1, 0, 0, 8'h21, 8'h22);
        step();
        drive(0, 0, 0, 8'h00, 8'h00);
        chk("post_rst_push", {count, pop_a0, pop_ra}, {5'd1, 8'h21, 8'h22});
        drive(0, 1, 0, 8'h00, 8'h00);
        step();
        drive(0, 0, 0, 8'h00, 8'h00);
        chk("post_rst_pop", {count, empty}, {5'd0, 1'b1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
